// File: rtl/l0_pkg.sv
// l0_pkg: shared constants, types and helpers for the L0 activation buffer.
//   L0_DEPTH_DEF  default entries per lane FIFO
//   L0_BW_DEF     default activation width per lane
//   l0_word_t     one lane word at the default width
//   l0_ptr_width  pointer width for a given depth (address bits plus one wrap bit)
package l0_pkg;

   localparam int unsigned L0_DEPTH_DEF = 64;
   localparam int unsigned L0_BW_DEF    = 4;

   typedef logic [L0_BW_DEF-1:0] l0_word_t;

   function automatic int unsigned l0_ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/l0_lane_fifo.sv
// l0_lane_fifo: one lane of the L0 buffer, a circular FIFO with registered read data.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-low reset (clears pointers and outputs, not memory)
//   i_wr_en    push i_wr_data; the caller guarantees the lane is not full
//   i_wr_data  lane word to push
//   i_rd_en    pop request; ignored while the lane is empty
//   o_data     last popped word, held between pops
//   o_valid    o_data was updated by a pop on the previous cycle
//   o_full     lane holds depth entries
module l0_lane_fifo
   import l0_pkg::*;
#(
   parameter int unsigned bw    = L0_BW_DEF,
   parameter int unsigned depth = L0_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_wr_en,
   input  logic [bw-1:0] i_wr_data,
   input  logic          i_rd_en,
   output logic [bw-1:0] o_data,
   output logic          o_valid,
   output logic          o_full
);

   localparam int unsigned PW = l0_ptr_width(depth);
   localparam int unsigned AW = PW - 1;

   logic [bw-1:0] r_mem [depth];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [bw-1:0] r_data;
   logic          r_valid;
   logic          w_empty;
   logic          w_pop;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   // Same address with opposite wrap bits means the writer is a full lap ahead.
   assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_pop   = i_rd_en && !w_empty;
   assign o_data  = r_data;
   assign o_valid = r_valid;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (reset && i_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         r_valid <= w_pop;
         if (w_pop) begin
            r_data   <= r_mem[r_rd_ptr[AW-1:0]];
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/l0_buffer.sv
// l0_buffer: staging buffer between the activation SRAM and the west edge of the MAC array.
// One FIFO per array row; a full SRAM word is pushed to every lane at once and each lane
// pops its own bw-bit stream.
// Build option: define L0_SKEW_EN to delay lane i's pop by i cycles (diagonal wavefront);
// otherwise all lanes pop together.
// Ports:
//   clk      clock, rising edge
//   reset    synchronous active-low reset
//   wr       push request for the word on in (dropped while o_ready is low)
//   in       SRAM word, lane i = in[bw*(i+1)-1 : bw*i]
//   rd       pop request with lane-0 timing
//   out      registered popped data, same lane packing as in
//   o_valid  per lane: out lane updated by a pop on the previous cycle
//   o_full   any lane full
//   o_ready  no lane full
module l0_buffer
   import l0_pkg::*;
#(
   parameter int unsigned row   = 8,
   parameter int unsigned bw    = L0_BW_DEF,
   parameter int unsigned depth = L0_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [row*bw-1:0] in,
   input  logic              rd,
   output logic [row*bw-1:0] out,
   output logic [row-1:0]    o_valid,
   output logic              o_full,
   output logic              o_ready
);

   logic [row-1:0] w_lane_full;
   logic [row-1:0] w_rd_en;
   logic           w_wr_fire;

   // Lanes differ in occupancy only while skewed pops drain, so the fullest lane gates writes.
   assign o_full    = |w_lane_full;
   assign o_ready   = ~o_full;
   assign w_wr_fire = wr && o_ready;

`ifdef L0_SKEW_EN
   // r_skew[i] is rd delayed by i cycles.
   logic [row-1:1] r_skew;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_skew <= '0;
      end else begin
         r_skew[1] <= rd;
         for (int i = 2; i < row; i++) begin
            r_skew[i] <= r_skew[i-1];
         end
      end
   end

   assign w_rd_en = {r_skew, rd};
`else
   assign w_rd_en = {row{rd}};
`endif

   for (genvar g = 0; g < row; g++) begin : g_lane
      l0_lane_fifo #(
         .bw   (bw),
         .depth(depth)
      ) u_lane (
         .clk      (clk),
         .reset    (reset),
         .i_wr_en  (w_wr_fire),
         .i_wr_data(in[g*bw +: bw]),
         .i_rd_en  (w_rd_en[g]),
         .o_data   (out[g*bw +: bw]),
         .o_valid  (o_valid[g]),
         .o_full   (w_lane_full[g])
      );
   end

endmodule

// File: tb/tb_l0_buffer.sv
// Bench for l0_buffer: per-lane queue reference model, directed scenarios and random traffic.
module tb_l0_buffer;

   localparam int unsigned ROW   = 8;
   localparam int unsigned BW    = 4;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned W     = ROW * BW;
   localparam int unsigned EW    = W + ROW + 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           wr;
   logic [W-1:0]   in;
   logic           rd;
   logic [W-1:0]   out;
   logic [ROW-1:0] o_valid;
   logic           o_full;
   logic           o_ready;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   l0_buffer #(
      .row  (ROW),
      .bw   (BW),
      .depth(DEPTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr),
      .in     (in),
      .rd     (rd),
      .out    (out),
      .o_valid(o_valid),
      .o_full (o_full),
      .o_ready(o_ready)
   );

   // Reference model: one queue per lane, rd history for the skewed variant.
   typedef logic [BW-1:0] lane_q_t[$];
   lane_q_t        q [ROW];
   logic [W-1:0]   m_out;
   logic [ROW-1:0] m_valid;
   logic [ROW-1:0] rd_hist;
   logic [EW-1:0]  exp_v;

   function automatic bit model_full();
      for (int i = 0; i < ROW; i++) begin
         if (q[i].size() == int'(DEPTH)) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Drive one cycle of stimulus, advance the model across the edge, land 1ns after the edge.
   task automatic tick(input bit w, input logic [W-1:0] d, input bit r, input bit do_rst);
      logic [ROW-1:0] en;
      bit             ready;
      wr    = w;
      in    = d;
      rd    = r;
      reset = do_rst ? 1'b0 : 1'b1;
      if (do_rst) begin
         for (int i = 0; i < ROW; i++) q[i].delete();
         m_out   = '0;
         m_valid = '0;
         rd_hist = '0;
      end else begin
         ready   = !model_full();
         rd_hist = {rd_hist[ROW-2:0], r};
`ifdef L0_SKEW_EN
         en = rd_hist;
`else
         en = {ROW{r}};
`endif
         for (int i = 0; i < ROW; i++) begin
            m_valid[i] = 1'b0;
            if (en[i] && q[i].size() > 0) begin
               m_out[i*BW +: BW] = q[i].pop_front();
               m_valid[i]        = 1'b1;
            end
         end
         if (w && ready) begin
            for (int i = 0; i < ROW; i++) q[i].push_back(d[i*BW +: BW]);
         end
      end
      exp_v = {m_out, m_valid, model_full(), !model_full()};
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b1);
      n_tests++;
      if ({out, o_valid, o_full, o_ready} !== {{W{1'b0}}, {ROW{1'b0}}, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset cyc%0d: got out=%h valid=%h full=%b ready=%b, want 0/0/0/1",
                  cyc, out, o_valid, o_full, o_ready);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] words [3];
      words[0] = 32'h76543210;
      words[1] = 32'hFEDCBA98;
      words[2] = 32'h0F0F0F0F;
      tick(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) tick(1'b1, words[k], 1'b0, 1'b0);
      for (int k = 0; k < 3 + int'(ROW); k++) begin
         tick(1'b0, '0, (k < 3), 1'b0);
         n_tests++;
         if ({out, o_valid, o_full, o_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL basic_pop cyc%0d: got %h/%h/%b/%b want %h", cyc, out, o_valid,
                     o_full, o_ready, exp_v);
         end
`ifndef L0_SKEW_EN
         if (k < 3) begin
            n_tests++;
            if (out !== words[k] || o_valid !== 8'hFF) begin
               n_fail++;
               $display("FAIL basic_word%0d: got out=%h valid=%h want out=%h valid=ff", k, out,
                        o_valid, words[k]);
            end
         end
`endif
      end
      // Pop on empty: nothing valid, data holds the last word.
      tick(1'b0, '0, 1'b1, 1'b0);
      n_tests++;
      if (o_valid !== '0 || out !== 32'h0F0F0F0F) begin
         n_fail++;
         $display("FAIL underflow: got out=%h valid=%h want out=0f0f0f0f valid=00", out, o_valid);
      end
   endtask

   task automatic test_fill_wrap();
      logic [W-1:0] d;
      tick(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < int'(DEPTH) + 1; k++) begin
         d = $urandom();
         tick(1'b1, d, 1'b0, 1'b0);
         if (k == int'(DEPTH) - 1) begin
            n_tests++;
            if (o_full !== 1'b1 || o_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL fill_full: got full=%b ready=%b want 1/0", o_full, o_ready);
            end
         end
      end
      for (int k = 0; k < int'(DEPTH) + int'(ROW); k++) begin
         tick(1'b0, '0, (k < int'(DEPTH)), 1'b0);
         n_tests++;
         if ({out, o_valid, o_full, o_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL fill_drain cyc%0d: got %h/%h/%b/%b want %h", cyc, out, o_valid,
                     o_full, o_ready, exp_v);
         end
      end
      for (int k = 0; k < 5; k++) begin
         d = $urandom();
         tick(1'b1, d, 1'b0, 1'b0);
         for (int j = 0; j < int'(ROW); j++) begin
            tick(1'b0, '0, (j == 0), 1'b0);
            n_tests++;
            if ({out, o_valid, o_full, o_ready} !== exp_v) begin
               n_fail++;
               $display("FAIL wrap_pair cyc%0d: got %h/%h/%b/%b want %h", cyc, out, o_valid,
                        o_full, o_ready, exp_v);
            end
         end
      end
   endtask

   task automatic test_full_wr_rd();
      tick(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < int'(DEPTH); k++) tick(1'b1, W'($urandom()), 1'b0, 1'b0);
      for (int k = 0; k < int'(ROW) + 1; k++) begin
         tick((k == 0), 32'hDEADBEEF, (k == 0), 1'b0);
         n_tests++;
         if ({out, o_valid, o_full, o_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL full_wr_rd cyc%0d: got %h/%h/%b/%b want %h", cyc, out, o_valid,
                     o_full, o_ready, exp_v);
         end
      end
   endtask

   task automatic test_skew_and_reset();
      // Single rd pulse with two words queued.
      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b1, 32'h89ABCDEF, 1'b0, 1'b0);
      tick(1'b1, 32'h01234567, 1'b0, 1'b0);
      for (int k = 0; k < int'(ROW) + 1; k++) begin
         tick(1'b0, '0, (k == 0), 1'b0);
         n_tests++;
         if ({out, o_valid, o_full, o_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL skew_pulse cyc%0d: got %h/%h/%b/%b want %h", cyc, out, o_valid,
                     o_full, o_ready, exp_v);
         end
      end
      // Reset while a skewed pop is in flight.
      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b1, 32'h13579BDF, 1'b0, 1'b0);
      tick(1'b1, 32'h2468ACE0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick(1'b0, '0, (k == 0), 1'b0);
      tick(1'b0, '0, 1'b0, 1'b1);
      n_tests++;
      if ({out, o_valid, o_full, o_ready} !== {{W{1'b0}}, {ROW{1'b0}}, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL mid_reset: got out=%h valid=%h full=%b ready=%b want 0/0/0/1", out,
                  o_valid, o_full, o_ready);
      end
      for (int k = 0; k < int'(ROW) + 2; k++) begin
         tick(1'b0, '0, (k >= int'(ROW)), 1'b0);
         n_tests++;
         if (o_valid !== '0 || out !== '0) begin
            n_fail++;
            $display("FAIL post_reset_pop cyc%0d: got out=%h valid=%h want 0/0", cyc, out,
                     o_valid);
         end
      end
   endtask

   task automatic test_wr_rd_empty();
      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b1, 32'hA5C3E1F7, 1'b1, 1'b0);
      n_tests++;
      if (o_valid !== '0) begin
         n_fail++;
         $display("FAIL wr_rd_empty: got valid=%h want 00", o_valid);
      end
      for (int k = 0; k < int'(ROW); k++) begin
         tick(1'b0, '0, (k == 0), 1'b0);
         n_tests++;
         if ({out, o_valid, o_full, o_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL wr_then_rd cyc%0d: got %h/%h/%b/%b want %h", cyc, out, o_valid,
                     o_full, o_ready, exp_v);
         end
      end
      n_tests++;
      if (out !== 32'hA5C3E1F7) begin
         n_fail++;
         $display("FAIL wr_then_rd_word: got out=%h want a5c3e1f7", out);
      end
   endtask

   task automatic test_random();
      bit w, r, x;
      tick(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 1500; k++) begin
         w = ($urandom_range(0, 99) < 60);
         r = ($urandom_range(0, 99) < 45);
         x = ($urandom_range(0, 299) == 0);
         tick(w, W'($urandom()), r, x);
         n_tests++;
         if ({out, o_valid, o_full, o_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL random cyc%0d: got %h/%h/%b/%b want %h", cyc, out, o_valid, o_full,
                     o_ready, exp_v);
         end
      end
   endtask

   initial begin
      reset   = 1'b0;
      wr      = 1'b0;
      rd      = 1'b0;
      in      = '0;
      m_out   = '0;
      m_valid = '0;
      rd_hist = '0;
      exp_v   = '0;
      test_reset();
      test_basic();
      test_fill_wrap();
      test_full_wr_rd();
      test_skew_and_reset();
      test_wr_rd_empty();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
